// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: fetch/decode/address/execute FSM driving datapath strobes.
// Optional single-step mode is enabled with macro CTRL_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int unsigned ILLEGAL_HALT = 0
) (
  input  logic       clk,
  input  logic       REST,
  input  logic [3:0] OPCODE,
  input  logic       STEP,
  output logic       PC_OUT,
  output logic       PC_INC,
  output logic       PC_LOAD,
  output logic       MAR_LOAD,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IR_LOAD,
  output logic       ACC_LOAD,
  output logic       ACC_OUT,
  output logic       B_LOAD,
  output logic       ALU_OUT,
  output logic       ALU_SUB,
  output logic       OUT_LOAD,
  output logic       HALTED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    StF0   = 3'd0,
    StF1   = 3'd1,
    StDec  = 3'd2,
    StA0   = 3'd3,
    StA1   = 3'd4,
    StE0   = 3'd5,
    StE1   = 3'd6,
    StHalt = 3'd7
  } state_t;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpOut = 4'h4;
  localparam logic [3:0] OpSta = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpHlt = 4'hF;

  state_t     state_q;
  state_t     dec_next;
  logic [3:0] op_q;
  logic       step_go;

`ifdef CTRL_SINGLE_STEP_EN
  assign step_go = STEP;
`else
  logic unused_step;
  assign unused_step = STEP;
  assign step_go     = 1'b1;
`endif

  // Only the DEC next-state looks at the live OPCODE; strobes use op_q.
  always_comb begin
    case (OPCODE)
      OpNop:                             dec_next = StF0;
      OpHlt:                             dec_next = StHalt;
      OpOut:                             dec_next = StE0;
      OpLda, OpAdd, OpSub, OpSta, OpJmp: dec_next = StA0;
      default:                           dec_next = (ILLEGAL_HALT != 0) ? StHalt : StF0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (REST) begin
      state_q <= StF0;
      op_q    <= 4'h0;
    end else begin
      unique case (state_q)
        StF0:   if (step_go) state_q <= StF1;
        StF1:   state_q <= StDec;
        StDec: begin
          op_q    <= OPCODE;
          state_q <= dec_next;
        end
        StA0:   state_q <= StA1;
        StA1:   state_q <= (op_q == OpJmp) ? StF0 : StE0;
        StE0:   state_q <= (op_q == OpAdd || op_q == OpSub) ? StE1 : StF0;
        StE1:   state_q <= StF0;
        StHalt: state_q <= StHalt;
      endcase
    end
  end

  always_comb begin
    PC_OUT   = 1'b0;
    PC_INC   = 1'b0;
    PC_LOAD  = 1'b0;
    MAR_LOAD = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    IR_LOAD  = 1'b0;
    ACC_LOAD = 1'b0;
    ACC_OUT  = 1'b0;
    B_LOAD   = 1'b0;
    ALU_OUT  = 1'b0;
    ALU_SUB  = 1'b0;
    OUT_LOAD = 1'b0;
    unique case (state_q)
      StF0: begin
        PC_OUT   = step_go;
        MAR_LOAD = step_go;
      end
      StF1: begin
        MEM_RD  = 1'b1;
        IR_LOAD = 1'b1;
        PC_INC  = 1'b1;
      end
      StA0: begin
        PC_OUT   = 1'b1;
        MAR_LOAD = 1'b1;
      end
      StA1: begin
        MEM_RD = 1'b1;
        if (op_q == OpJmp) begin
          PC_LOAD = 1'b1;
        end else begin
          MAR_LOAD = 1'b1;
          PC_INC   = 1'b1;
        end
      end
      StE0: begin
        case (op_q)
          OpLda: begin
            MEM_RD   = 1'b1;
            ACC_LOAD = 1'b1;
          end
          OpAdd, OpSub: begin
            MEM_RD = 1'b1;
            B_LOAD = 1'b1;
          end
          OpSta: begin
            ACC_OUT = 1'b1;
            MEM_WR  = 1'b1;
          end
          OpOut: begin
            ACC_OUT  = 1'b1;
            OUT_LOAD = 1'b1;
          end
          default: ;
        endcase
      end
      StE1: begin
        ALU_OUT  = 1'b1;
        ACC_LOAD = 1'b1;
        ALU_SUB  = (op_q == OpSub);
      end
      StDec, StHalt: ;
    endcase
  end

  assign STATE  = state_q;
  assign HALTED = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected state/strobe records are queued
// when an opcode is issued and compared at each falling edge.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0]  st;
    logic        halted;
    logic [12:0] strb;
  } exp_t;

  // strobe vector order: PC_OUT PC_INC PC_LOAD MAR_LOAD MEM_RD MEM_WR IR_LOAD
  //                      ACC_LOAD ACC_OUT B_LOAD ALU_OUT ALU_SUB OUT_LOAD
  localparam logic [12:0] M_PC_OUT   = 13'h1000;
  localparam logic [12:0] M_PC_INC   = 13'h0800;
  localparam logic [12:0] M_PC_LOAD  = 13'h0400;
  localparam logic [12:0] M_MAR_LOAD = 13'h0200;
  localparam logic [12:0] M_MEM_RD   = 13'h0100;
  localparam logic [12:0] M_MEM_WR   = 13'h0080;
  localparam logic [12:0] M_IR_LOAD  = 13'h0040;
  localparam logic [12:0] M_ACC_LOAD = 13'h0020;
  localparam logic [12:0] M_ACC_OUT  = 13'h0010;
  localparam logic [12:0] M_B_LOAD   = 13'h0008;
  localparam logic [12:0] M_ALU_OUT  = 13'h0004;
  localparam logic [12:0] M_ALU_SUB  = 13'h0002;
  localparam logic [12:0] M_OUT_LOAD = 13'h0001;

  logic        clk = 1'b0;
  logic        REST;
  logic        STEP;
  logic [3:0]  OPCODE;
  logic [12:0] s0, s1;
  logic        halted0, halted1;
  logic [2:0]  state0, state1;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  control_sequencer #(.ILLEGAL_HALT(0)) dut0 (
    .clk(clk), .REST(REST), .OPCODE(OPCODE), .STEP(STEP),
    .PC_OUT(s0[12]), .PC_INC(s0[11]), .PC_LOAD(s0[10]), .MAR_LOAD(s0[9]), .MEM_RD(s0[8]),
    .MEM_WR(s0[7]), .IR_LOAD(s0[6]), .ACC_LOAD(s0[5]), .ACC_OUT(s0[4]), .B_LOAD(s0[3]),
    .ALU_OUT(s0[2]), .ALU_SUB(s0[1]), .OUT_LOAD(s0[0]), .HALTED(halted0), .STATE(state0)
  );

  control_sequencer #(.ILLEGAL_HALT(1)) dut1 (
    .clk(clk), .REST(REST), .OPCODE(OPCODE), .STEP(STEP),
    .PC_OUT(s1[12]), .PC_INC(s1[11]), .PC_LOAD(s1[10]), .MAR_LOAD(s1[9]), .MEM_RD(s1[8]),
    .MEM_WR(s1[7]), .IR_LOAD(s1[6]), .ACC_LOAD(s1[5]), .ACC_OUT(s1[4]), .B_LOAD(s1[3]),
    .ALU_OUT(s1[2]), .ALU_SUB(s1[1]), .OUT_LOAD(s1[0]), .HALTED(halted1), .STATE(state1)
  );

  function automatic exp_t observe();
    return {state0, halted0, s0};
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic [12:0] strb);
    return {st, (st == 3'd7), strb};
  endfunction

  // Expected per-cycle trace of one instruction starting in F0.
  task automatic push_op(input logic [3:0] op);
    exp_q.push_back(mk(3'd0, M_PC_OUT | M_MAR_LOAD));
    exp_q.push_back(mk(3'd1, M_MEM_RD | M_IR_LOAD | M_PC_INC));
    exp_q.push_back(mk(3'd2, 13'h0));
    if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6}) begin
      exp_q.push_back(mk(3'd3, M_PC_OUT | M_MAR_LOAD));
      if (op == 4'h6) exp_q.push_back(mk(3'd4, M_MEM_RD | M_PC_LOAD));
      else exp_q.push_back(mk(3'd4, M_MEM_RD | M_MAR_LOAD | M_PC_INC));
    end
    case (op)
      4'h1: exp_q.push_back(mk(3'd5, M_MEM_RD | M_ACC_LOAD));
      4'h5: exp_q.push_back(mk(3'd5, M_ACC_OUT | M_MEM_WR));
      4'h4: exp_q.push_back(mk(3'd5, M_ACC_OUT | M_OUT_LOAD));
      4'h2: begin
        exp_q.push_back(mk(3'd5, M_MEM_RD | M_B_LOAD));
        exp_q.push_back(mk(3'd6, M_ALU_OUT | M_ACC_LOAD));
      end
      4'h3: begin
        exp_q.push_back(mk(3'd5, M_MEM_RD | M_B_LOAD));
        exp_q.push_back(mk(3'd6, M_ALU_OUT | M_ACC_LOAD | M_ALU_SUB));
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    REST = 1'b1;
    @(negedge clk);
    REST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    OPCODE = 4'h1;
    repeat (4) @(negedge clk);
    do_reset();
    o = observe();
    n_checks++;
    if (o !== mk(3'd0, M_PC_OUT | M_MAR_LOAD))
      $display("FAIL reset_mid_instr: got state=%0d halted=%0b strb=%b, want state=0 halted=0 strb=%b",
               o.st, o.halted, o.strb, M_PC_OUT | M_MAR_LOAD);
    else n_pass++;
  endtask

  task automatic test_instructions();
    logic [3:0] ops[5] = '{4'h1, 4'h3, 4'h2, 4'h5, 4'h4};
    exp_t o, e;
    int n, pc_inc;
    for (int k = 0; k < 5; k++) begin
      push_op(ops[k]);
      OPCODE = ops[k];
      n = exp_q.size();
      pc_inc = 0;
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        o = observe();
        pc_inc += int'(o.strb[11]);
        n_checks++;
        if (o !== e)
          $display("FAIL op%h cycle%0d: got state=%0d halted=%0b strb=%b, want state=%0d halted=%0b strb=%b",
                   ops[k], i, o.st, o.halted, o.strb, e.st, e.halted, e.strb);
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ((ops[k] == 4'h4 && pc_inc !== 1) || (ops[k] != 4'h4 && pc_inc !== 2))
        $display("FAIL op%h pc_inc_count: got %0d, want %0d", ops[k], pc_inc,
                 (ops[k] == 4'h4) ? 1 : 2);
      else n_pass++;
    end
  endtask

  task automatic test_jmp();
    exp_t o, e;
    int n;
    push_op(4'h6);
    OPCODE = 4'h6;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL jmp cycle%0d: got state=%0d strb=%b, want state=%0d strb=%b",
                 i, o.st, o.strb, e.st, e.strb);
      else n_pass++;
      if (i == 3) OPCODE = 4'h0;  // change during A0 must not affect A1
      @(negedge clk);
    end
    n_checks++;
    if (state0 !== 3'd0) $display("FAIL jmp_next_f0: got state=%0d, want 0", state0);
    else n_pass++;
  endtask

  task automatic test_halt();
    exp_t o, e;
    int n;
    push_op(4'hF);
    repeat (20) exp_q.push_back(mk(3'd7, 13'h0));
    OPCODE = 4'hF;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL halt cycle%0d: got state=%0d halted=%0b strb=%b, want state=%0d halted=%0b strb=%b",
                 i, o.st, o.halted, o.strb, e.st, e.halted, e.strb);
      else n_pass++;
      if (i == 5) OPCODE = 4'h1;
      @(negedge clk);
    end
    do_reset();
    n_checks++;
    if (state0 !== 3'd0 || halted0 !== 1'b0 || state1 !== 3'd0 || halted1 !== 1'b0)
      $display("FAIL halt_reset: got state=%0d/%0d halted=%0b/%0b, want 0/0 0/0",
               state0, state1, halted0, halted1);
    else n_pass++;
  endtask

  task automatic test_undefined();
    exp_t o, e;
    int n;
    push_op(4'hA);
    OPCODE = 4'hA;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL undef cycle%0d: got state=%0d strb=%b, want state=%0d strb=%b",
                 i, o.st, o.strb, e.st, e.strb);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (state0 !== 3'd0 || halted0 !== 1'b0)
      $display("FAIL undef_nop: got state=%0d halted=%0b, want 0 0", state0, halted0);
    else n_pass++;
    n_checks++;
    if (state1 !== 3'd7 || halted1 !== 1'b1 || s1 !== 13'h0)
      $display("FAIL undef_halt: got state=%0d halted=%0b strb=%b, want 7 1 0", state1, halted1, s1);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [3:0] pool[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC};
    logic [3:0] op;
    exp_t o, e;
    int n;
    for (int k = 0; k < 10; k++) begin
      op = pool[$urandom_range(0, 7)];
      push_op(op);
      OPCODE = op;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        o = observe();
        n_checks++;
        if (o !== e)
          $display("FAIL b2b op%h cycle%0d: got state=%0d strb=%b, want state=%0d strb=%b",
                   op, i, o.st, o.strb, e.st, e.strb);
        else n_pass++;
        @(negedge clk);
      end
    end
    do_reset();
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic test_step();
    exp_t o, e;
    int n;
    STEP = 1'b0;
    OPCODE = 4'h0;
    do_reset();
    repeat (10) exp_q.push_back(mk(3'd0, 13'h0));
    exp_q.push_back(mk(3'd0, M_PC_OUT | M_MAR_LOAD));
    exp_q.push_back(mk(3'd1, M_MEM_RD | M_IR_LOAD | M_PC_INC));
    exp_q.push_back(mk(3'd2, 13'h0));
    repeat (4) exp_q.push_back(mk(3'd0, 13'h0));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      STEP = (i == 10);
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL step cycle%0d: got state=%0d strb=%b, want state=%0d strb=%b",
                 i, o.st, o.strb, e.st, e.strb);
      else n_pass++;
      @(negedge clk);
    end
    STEP = 1'b1;
  endtask
`else
  task automatic test_step();
    exp_t o, e;
    int n;
    push_op(4'h2);
    OPCODE = 4'h2;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      STEP = i[0];
      e = exp_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e)
        $display("FAIL step_ignored cycle%0d: got state=%0d strb=%b, want state=%0d strb=%b",
                 i, o.st, o.strb, e.st, e.strb);
      else n_pass++;
      @(negedge clk);
    end
    STEP = 1'b0;
  endtask
`endif

  initial begin
    REST   = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    STEP   = 1'b1;
`else
    STEP   = 1'b0;
`endif
    OPCODE = 4'h0;
    @(negedge clk);
    @(negedge clk);
    REST = 1'b0;
    test_reset();
    test_instructions();
    test_jmp();
    test_halt();
    test_undefined();
    test_back_to_back();
    test_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
